// File: rtl/me_stage_if.sv
// me_stage_if: data-bus handshake between the memory stage and the data memory.
interface me_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  wmask;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  modport master (output req, we, addr, wmask, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wmask, wdata, output rdata, ack);
endinterface

// File: rtl/me_stage.sv
// me_stage: pipeline memory stage; issues aligned loads/stores on the data bus,
// stalls the pipe until ack or timeout, and extends load data for write-back.
module me_stage #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              me_w_enable,
  input  logic [4:0]        me_w_addr,
  input  logic [31:0]       me_w_data,
  input  logic [3:0]        me_mem_op,
  input  logic [31:0]       me_mem_addr,
  input  logic [31:0]       me_mem_sdata,
  input  logic [5:0]        stall,
  output logic              wb_w_enable,
  output logic [4:0]        wb_w_addr,
  output logic [31:0]       wb_w_data,
  output logic              stall_req,
  me_stage_if.master        mem,
  output logic              misalign,
  output logic              timeout
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t      r_state, w_next;
  logic [7:0]  r_cnt, w_cnt;
  logic        r_rst, r_timeout, r_wb_en;
  logic [4:0]  r_wb_addr;
  logic [31:0] r_wb_data;
  logic        w_ld, w_st, w_mis, w_go, w_bus, w_ack_done, w_to, w_unused_stall;
  logic [1:0]  w_a;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;
  assign w_unused_stall = &stall[4:0];
  assign w_a    = me_mem_addr[1:0];
  assign w_ld   = me_mem_op >= 4'd1 && me_mem_op <= 4'd5;
  assign w_st   = me_mem_op >= 4'd6 && me_mem_op <= 4'd8;
  assign w_mis  = ((me_mem_op == 4'd2 || me_mem_op == 4'd5 || me_mem_op == 4'd7) && w_a[0]) ||
                  ((me_mem_op == 4'd3 || me_mem_op == 4'd8) && |w_a);
  // r_rst keeps every output quiet until rst is sampled high again
  assign w_go   = !r_rst && r_state == IDLE && (w_ld || w_st) && !w_mis;
  assign w_bus  = w_go || (!r_rst && r_state == WAIT);
  assign w_byte = 8'(mem.rdata >> {w_a, 3'b000});
  assign w_half = w_a[1] ? mem.rdata[31:16] : mem.rdata[15:0];
  assign w_ext  = me_mem_op == 4'd1 ? {{24{w_byte[7]}}, w_byte} :
                  me_mem_op == 4'd2 ? {{16{w_half[15]}}, w_half} :
                  me_mem_op == 4'd4 ? {24'd0, w_byte} :
                  me_mem_op == 4'd5 ? {16'd0, w_half} : mem.rdata;
  always_comb begin
    w_next     = r_state;
    w_cnt      = r_cnt;
    w_ack_done = 1'b0;
    w_to       = 1'b0;
    if (r_state == IDLE) begin
      w_cnt  = 8'd0;
      w_next = w_go ? WAIT : IDLE;
    end else if (r_state == WAIT) begin
      if (mem.ack) begin
        w_ack_done = 1'b1;
        w_next     = DONE;
      end else begin
        w_cnt = r_cnt + 8'd1;
        if (w_cnt == 8'(ACK_TIMEOUT)) begin
          w_to   = 1'b1;
          w_next = DONE;
        end
      end
    end else begin
      w_next = stall[5] ? DONE : IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= 8'd0;
      r_rst     <= 1'b1;
      r_timeout <= 1'b0;
      r_wb_en   <= 1'b0;
      r_wb_addr <= 5'd0;
      r_wb_data <= 32'd0;
    end else begin
      r_state   <= w_next;
      r_cnt     <= w_cnt;
      r_rst     <= 1'b0;
      r_timeout <= w_to;
      if (w_ack_done || w_to) begin
        r_wb_en   <= w_ack_done && w_ld && me_w_enable;
        r_wb_addr <= me_w_addr;
        r_wb_data <= (w_ack_done && w_ld) ? w_ext : 32'd0;
      end
    end
  end
  assign mem.req     = w_bus;
  assign mem.we      = w_bus && w_st;
  assign mem.addr    = w_bus ? {me_mem_addr[31:2], 2'b00} : 32'd0;
  assign mem.wmask   = !(w_bus && w_st) ? 4'd0 :
                       me_mem_op == 4'd6 ? 4'b0001 << w_a :
                       me_mem_op == 4'd7 ? (w_a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign mem.wdata   = !(w_bus && w_st) ? 32'd0 :
                       me_mem_op == 4'd6 ? {4{me_mem_sdata[7:0]}} :
                       me_mem_op == 4'd7 ? {2{me_mem_sdata[15:0]}} : me_mem_sdata;
  assign stall_req   = w_bus;
  assign misalign    = !r_rst && r_state == IDLE && w_mis;
  assign timeout     = r_timeout;
  assign wb_w_enable = r_rst ? 1'b0 : r_state == DONE ? r_wb_en :
                       (r_state == IDLE && !w_ld && !w_st) ? me_w_enable : 1'b0;
  assign wb_w_addr   = r_rst ? 5'd0 : r_state == DONE ? r_wb_addr : me_w_addr;
  assign wb_w_data   = r_rst ? 32'd0 : r_state == DONE ? r_wb_data : me_w_data;
endmodule
